// File: rtl/seg7_capture.sv
// seg7_capture: samples a multiplexed, active-low 4-digit 7-segment display bus
// and turns it back into four BCD digits, one complete frame at a time.
module seg7_capture #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 250_000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [0:6] seg,
    input  logic [3:0] digit,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [3:0] thousands,
    output logic       frame_valid,
    output logic       pattern_err,
    output logic       stale
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_SEL = 2'd0,
        SETTLE   = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t        state;
    logic [0:6]    seg_q;
    logic [0:6]    seg_p;
    logic [3:0]    digit_q;
    logic [3:0]    digit_p;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [3:0]    mask;
    logic [3:0]    shadow [4];

    logic          legal_c;
    logic [1:0]    slot_c;
    logic          digit_chg_c;
    logic          changed_c;
    logic [3:0]    bcd_c;
    logic          bcd_ok_c;
    logic          settle_done_c;
    logic          cap_ok_c;
    logic          cap_bad_c;
    logic          frame_c;
    logic          timeout_c;
    logic [3:0]    mask_next_c;

    // Anode select: legality and which shadow slot it addresses
    always_comb begin
        legal_c = 1'b1;
        slot_c  = 2'd0;
        case (digit_q)
            4'b1110: slot_c = 2'd0;
            4'b1101: slot_c = 2'd1;
            4'b1011: slot_c = 2'd2;
            4'b0111: slot_c = 2'd3;
            default: legal_c = 1'b0;
        endcase
    end

    // Segment pattern to BCD; anything off-table is flagged illegal
    always_comb begin
        bcd_c    = 4'd0;
        bcd_ok_c = 1'b1;
        case (seg_q)
            7'b0000001: bcd_c = 4'd0;
            7'b1001111: bcd_c = 4'd1;
            7'b0010010: bcd_c = 4'd2;
            7'b0000110: bcd_c = 4'd3;
            7'b1001100: bcd_c = 4'd4;
            7'b0100100: bcd_c = 4'd5;
            7'b0100000: bcd_c = 4'd6;
            7'b0001111: bcd_c = 4'd7;
            7'b0000000: bcd_c = 4'd8;
            7'b0000100: bcd_c = 4'd9;
            default:    bcd_ok_c = 1'b0;
        endcase
    end

    // Capture, frame-completion and timeout events for this cycle
    always_comb begin
        digit_chg_c   = (digit_q != digit_p);
        changed_c     = digit_chg_c || (seg_q != seg_p);
        settle_done_c = (state == SETTLE) && legal_c && !changed_c
                        && (settle_cnt == SETTLE_LAST);
        cap_ok_c      = settle_done_c && bcd_ok_c;
        cap_bad_c     = settle_done_c && !bcd_ok_c;
        frame_c       = (mask == 4'b1111);
        timeout_c     = (timeout_cnt == TIMEOUT_LAST) && !cap_ok_c;
    end

    // Next captured mask: frame copy or timeout empties it, a same-cycle capture still lands
    always_comb begin
        mask_next_c = mask;
        if (frame_c || timeout_c) begin
            mask_next_c = 4'b0000;
        end
        if (cap_ok_c) begin
            mask_next_c[slot_c] = 1'b1;
        end
        if (cap_bad_c) begin
            mask_next_c[slot_c] = 1'b0;
        end
    end

    // Input registers, settle FSM, shadow slots, frame output and timeout tracking
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state       <= WAIT_SEL;
            seg_q       <= '1;
            seg_p       <= '1;
            digit_q     <= '1;
            digit_p     <= '1;
            settle_cnt  <= '0;
            timeout_cnt <= '0;
            mask        <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 4'd0;
            end
            ones        <= 4'd0;
            tens        <= 4'd0;
            hundreds    <= 4'd0;
            thousands   <= 4'd0;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            stale       <= 1'b1;
        end else begin
            seg_q       <= seg;
            digit_q     <= digit;
            seg_p       <= seg_q;
            digit_p     <= digit_q;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;

            case (state)
                WAIT_SEL: begin
                    if (legal_c) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (!legal_c) begin
                        state <= WAIT_SEL;
                    end else if (changed_c) begin
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state <= HOLD;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                HOLD: begin
                    if (!legal_c) begin
                        state <= WAIT_SEL;
                    end else if (digit_chg_c) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end
                end
                default: state <= WAIT_SEL;
            endcase

            if (cap_ok_c) begin
                shadow[slot_c] <= bcd_c;
            end
            if (cap_bad_c) begin
                pattern_err <= 1'b1;
            end
            mask <= mask_next_c;

            if (frame_c) begin
                ones        <= shadow[0];
                tens        <= shadow[1];
                hundreds    <= shadow[2];
                thousands   <= shadow[3];
                frame_valid <= 1'b1;
            end

            if (cap_ok_c) begin
                timeout_cnt <= '0;
            end else if (timeout_cnt != TIMEOUT_LAST) begin
                timeout_cnt <= timeout_cnt + TW'(1);
            end

            if (frame_c) begin
                stale <= 1'b0;
            end else if (timeout_c) begin
                stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed, table-driven checks of seg7_capture with short settle/timeout.
module tb_seg7_capture;

    logic       clk_100MHz;
    logic       reset;
    logic [0:6] seg;
    logic [3:0] digit;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;
    logic       frame_valid;
    logic       pattern_err;
    logic       stale;

    int tests = 0;
    int fails = 0;

    seg7_capture #(
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .seg        (seg),
        .digit      (digit),
        .ones       (ones),
        .tens       (tens),
        .hundreds   (hundreds),
        .thousands  (thousands),
        .frame_valid(frame_valid),
        .pattern_err(pattern_err),
        .stale      (stale)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        logic [3:0]  dig;
        logic [0:6]  sg;
        int          cyc;
        int          fv;
        int          err;
        logic        st;
        logic [15:0] bcd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] d, input logic [0:6] s, input int n,
                                input int fv, input int err, input logic st,
                                input logic [15:0] bcd);
        vec_t v;
        v.dig = d;
        v.sg  = s;
        v.cyc = n;
        v.fv  = fv;
        v.err = err;
        v.st  = st;
        v.bcd = bcd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one digit/segment pair for n cycles, counting output pulses at negedges
    task automatic run(input logic [3:0] d, input logic [0:6] s, input int n,
                       output int fvn, output int ern);
        digit = d;
        seg   = s;
        fvn   = 0;
        ern   = 0;
        repeat (n) begin
            @(negedge clk_100MHz);
            if (frame_valid) fvn++;
            if (pattern_err) ern++;
        end
    endtask

    function automatic logic [15:0] outs();
        return {thousands, hundreds, tens, ones};
    endfunction

    initial begin
        int a, b, fvt, ert;

        // Scan 1,2,3,4 then idle past the timeout
        tbl.push_back(mk(4'b0111, 7'b1001111, 20, 0, 0, 1'b1, 16'h0000));
        tbl.push_back(mk(4'b1011, 7'b0010010, 20, 0, 0, 1'b1, 16'h0000));
        tbl.push_back(mk(4'b1101, 7'b0000110, 20, 0, 0, 1'b1, 16'h0000));
        tbl.push_back(mk(4'b1110, 7'b1001100, 20, 1, 0, 1'b0, 16'h1234));
        tbl.push_back(mk(4'b1111, 7'b1111111, 70, 0, 0, 1'b1, 16'h1234));
        // Blank ones slot, then a corrected rescan (thousands overwritten 8 -> 6)
        tbl.push_back(mk(4'b0111, 7'b0000000, 20, 0, 0, 1'b1, 16'h1234));
        tbl.push_back(mk(4'b1011, 7'b0100100, 20, 0, 0, 1'b1, 16'h1234));
        tbl.push_back(mk(4'b1101, 7'b0001111, 20, 0, 0, 1'b1, 16'h1234));
        tbl.push_back(mk(4'b1110, 7'b1111111, 20, 0, 1, 1'b1, 16'h1234));
        tbl.push_back(mk(4'b0111, 7'b0100000, 20, 0, 0, 1'b1, 16'h1234));
        tbl.push_back(mk(4'b1011, 7'b0000001, 20, 0, 0, 1'b1, 16'h1234));
        tbl.push_back(mk(4'b1101, 7'b0000100, 20, 0, 0, 1'b1, 16'h1234));
        tbl.push_back(mk(4'b1110, 7'b0010010, 20, 1, 0, 1'b0, 16'h6092));
        // Continuous 9999 scan, three rounds
        for (int r = 0; r < 3; r++) begin
            tbl.push_back(mk(4'b0111, 7'b0000100, 10, 0, 0, 1'b0, (r == 0) ? 16'h6092 : 16'h9999));
            tbl.push_back(mk(4'b1011, 7'b0000100, 10, 0, 0, 1'b0, (r == 0) ? 16'h6092 : 16'h9999));
            tbl.push_back(mk(4'b1101, 7'b0000100, 10, 0, 0, 1'b0, (r == 0) ? 16'h6092 : 16'h9999));
            tbl.push_back(mk(4'b1110, 7'b0000100, 10, 1, 0, 1'b0, 16'h9999));
        end

        reset = 1'b1;
        digit = 4'b1111;
        seg   = 7'b1111111;
        repeat (3) @(negedge clk_100MHz);
        check("reset_outs", 32'(outs()), 32'h0000);
        check("reset_fv", 32'(frame_valid), 32'd0);
        check("reset_err", 32'(pattern_err), 32'd0);
        check("reset_stale", 32'(stale), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i].dig, tbl[i].sg, tbl[i].cyc, a, b);
            check($sformatf("step%0d_fv", i), 32'(a), 32'(tbl[i].fv));
            check($sformatf("step%0d_err", i), 32'(b), 32'(tbl[i].err));
            check($sformatf("step%0d_stale", i), 32'(stale), 32'(tbl[i].st));
            check($sformatf("step%0d_outs", i), 32'(outs()), 32'(tbl[i].bcd));
        end

        // Ones slot with segments toggling every 2 cycles never settles
        run(4'b0111, 7'b1001111, 10, a, b);
        run(4'b1011, 7'b0010010, 10, a, b);
        run(4'b1101, 7'b0000110, 10, a, b);
        fvt = 0;
        ert = 0;
        for (int i = 0; i < 12; i++) begin
            run(4'b1110, (i % 2 == 1) ? 7'b0000000 : 7'b1001100, 2, a, b);
            fvt += a;
            ert += b;
        end
        check("toggle_fv", 32'(fvt), 32'd0);
        check("toggle_err", 32'(ert), 32'd0);
        check("toggle_outs", 32'(outs()), 32'h9999);
        run(4'b1110, 7'b1001100, 10, a, b);
        check("stable_fv", 32'(a), 32'd1);
        check("stable_outs", 32'(outs()), 32'h1234);

        // Reset with three slots captured discards them
        run(4'b0111, 7'b0100100, 10, a, b);
        run(4'b1011, 7'b0100000, 10, a, b);
        run(4'b1101, 7'b0001111, 10, a, b);
        reset = 1'b1;
        run(4'b1101, 7'b0001111, 2, a, b);
        reset = 1'b0;
        fvt = a;
        run(4'b1110, 7'b1001111, 1, a, b);
        fvt += a;
        check("rst_mid_fv", 32'(fvt), 32'd0);
        check("rst_mid_outs", 32'(outs()), 32'h0000);
        check("rst_mid_stale", 32'(stale), 32'd1);
        run(4'b1110, 7'b1001111, 20, a, b);
        check("post_rst_fv", 32'(a), 32'd0);
        check("post_rst_outs", 32'(outs()), 32'h0000);
        check("post_rst_stale", 32'(stale), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
